// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiplier SRAM datapath.
// Holds the SRAM geometry and the port arbiter state encoding.
package mm_pkg;

    localparam int unsigned SRAM_AW = 10;
    localparam int unsigned SRAM_DW = 128;

    typedef enum logic {
        ARB_IDLE,
        ARB_BURST
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first asserted
// request found searching upward from ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic found;

    // Distance of requester j from ptr decides priority; the modulo keeps an
    // out-of-range ptr from starving everyone.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (!found && req[j] &&
                    ((j + NUM_REQ - (32'(ptr) % NUM_REQ)) % NUM_REQ) == k) begin
                    grant[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin, burst-locking arbiter sharing one single-port SRAM among
// NUM_REQ requesters; read responses return one cycle after acceptance.
module sram_port_arbiter
    import mm_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned AW      = SRAM_AW,
    parameter int unsigned DW      = SRAM_DW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [NUM_REQ-1:0]    req_last,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [DW-1:0]         rsp_rdata,
    output logic                  sram_we,
    output logic [AW-1:0]         sram_addr,
    output logic [DW-1:0]         sram_din,
    input  logic [DW-1:0]         sram_dout
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t           state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        owner_q, owner_d;
    logic                 rsp_v_q;
    logic [PW-1:0]        rsp_id_q;

    logic [NUM_REQ-1:0]   rr_grant;
    logic [NUM_REQ-1:0]   grant;
    logic [PW-1:0]        sel_idx;
    logic                 sel_we;
    logic                 sel_last;
    logic [AW-1:0]        sel_addr;
    logic [DW-1:0]        sel_din;
    logic                 accept;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] idx);
        next_ptr = (32'(idx) >= NUM_REQ - 1) ? '0 : idx + 1'b1;
    endfunction

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (rr_grant)
    );

    // During a burst only the owner may proceed; a gap leaves the SRAM idle.
    always_comb begin
        grant = '0;
        if (!rst) begin
            if (state_q == ARB_IDLE) begin
                grant = rr_grant;
            end else begin
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (PW'(i) == owner_q) grant[i] = req_valid[i];
                end
            end
        end
    end

    always_comb begin
        sel_idx  = '0;
        sel_we   = 1'b0;
        sel_last = 1'b0;
        sel_addr = '0;
        sel_din  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_idx  = PW'(i);
                sel_we   = req_we[i];
                sel_last = req_last[i];
                sel_addr = req_addr[i*AW +: AW];
                sel_din  = req_wdata[i*DW +: DW];
            end
        end
    end

    assign accept    = |grant;
    assign req_ready = grant;
    assign sram_we   = sel_we;
    assign sram_addr = sel_addr;
    assign sram_din  = sel_din;
    assign rsp_rdata = sram_dout;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        case (state_q)
            ARB_IDLE: begin
                if (accept) begin
                    if (sel_last) begin
                        ptr_d = next_ptr(sel_idx);
                    end else begin
                        state_d = ARB_BURST;
                        owner_d = sel_idx;
                    end
                end
            end
            ARB_BURST: begin
                if (accept && sel_last) begin
                    state_d = ARB_IDLE;
                    ptr_d   = next_ptr(owner_q);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            rsp_v_q  <= 1'b0;
            rsp_id_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            rsp_v_q  <= accept && !sel_we;
            rsp_id_q <= sel_idx;
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = !rst && rsp_v_q && (rsp_id_q == PW'(i));
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter with a behavioural SRAM model:
// a per-cycle vector table followed by a hand-written burst-read sequence.
module tb_sram_port_arbiter;

    localparam int unsigned NR = 2;
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 128;

    localparam logic [DW-1:0] Z   = '0;
    localparam logic [DW-1:0] A5  = {16{8'hA5}};
    localparam logic [DW-1:0] D0  = {4{32'hD0D0_0000}};
    localparam logic [DW-1:0] D1  = {4{32'hD1D1_1111}};
    localparam logic [DW-1:0] D3  = {4{32'hD3D3_3333}};
    localparam logic [DW-1:0] B0  = {4{32'hB0B0_0000}};
    localparam logic [DW-1:0] B1  = {4{32'hB1B1_1111}};
    localparam logic [DW-1:0] B2  = {4{32'hB2B2_2222}};
    localparam logic [DW-1:0] B3  = {4{32'hB3B3_3333}};
    localparam logic [DW-1:0] G0  = {4{32'h6060_0606}};
    localparam logic [DW-1:0] G1  = {4{32'h6161_1616}};
    localparam logic [DW-1:0] ONE = 128'd1;
    localparam logic [DW-1:0] TWO = 128'd2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid, req_we, req_last;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     req_ready, rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              sram_we;
    logic [AW-1:0]     sram_addr;
    logic [DW-1:0]     sram_din;
    logic [DW-1:0]     sram_dout = '0;

    logic [DW-1:0]     mem [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // SRAM model: registered read, dout held during a write.
    always @(posedge clk) begin
        if (sram_we) mem[sram_addr] <= sram_din;
        else         sram_dout <= mem[sram_addr];
    end

    sram_port_arbiter #(
        .NUM_REQ (NR),
        .AW      (AW),
        .DW      (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_last  (req_last),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout)
    );

    typedef struct {
        logic          rst;
        logic [1:0]    v, we, last;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic [1:0]    rdy, rsp;
        logic [DW-1:0] rdata;
        logic          swe;
        logic [AW-1:0] saddr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic [1:0] v, we, last,
                                input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                                input logic [1:0] rdy, rsp, input logic [DW-1:0] rdata,
                                input logic swe, input logic [AW-1:0] saddr);
        vec_t t;
        t.rst = r; t.v = v; t.we = we; t.last = last;
        t.a0 = a0; t.d0 = d0; t.a1 = a1; t.d1 = d1;
        t.rdy = rdy; t.rsp = rsp; t.rdata = rdata; t.swe = swe; t.saddr = saddr;
        return t;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    initial begin
        // Reset, single write + read
        tbl.push_back(mk(1, 2'b00, 2'b00, 2'b11, 10'h000, Z,   10'h000, Z,   2'b00, 2'b00, Z,   1'b0, 10'h000));
        tbl.push_back(mk(0, 2'b01, 2'b01, 2'b11, 10'h005, A5,  10'h000, Z,   2'b01, 2'b00, Z,   1'b1, 10'h005));
        tbl.push_back(mk(0, 2'b01, 2'b00, 2'b11, 10'h005, Z,   10'h000, Z,   2'b01, 2'b00, Z,   1'b0, 10'h005));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b11, 10'h000, Z,   10'h000, Z,   2'b00, 2'b01, A5,  1'b0, 10'h000));
        // Preload and round-robin reads
        tbl.push_back(mk(0, 2'b01, 2'b01, 2'b11, 10'h020, D0,  10'h000, Z,   2'b01, 2'b00, Z,   1'b1, 10'h020));
        tbl.push_back(mk(0, 2'b10, 2'b10, 2'b11, 10'h000, Z,   10'h021, D1,  2'b10, 2'b00, Z,   1'b1, 10'h021));
        tbl.push_back(mk(0, 2'b11, 2'b00, 2'b11, 10'h020, Z,   10'h021, Z,   2'b01, 2'b00, Z,   1'b0, 10'h020));
        tbl.push_back(mk(0, 2'b11, 2'b00, 2'b11, 10'h020, Z,   10'h021, Z,   2'b10, 2'b01, D0,  1'b0, 10'h021));
        tbl.push_back(mk(0, 2'b11, 2'b00, 2'b11, 10'h020, Z,   10'h021, Z,   2'b01, 2'b10, D1,  1'b0, 10'h020));
        tbl.push_back(mk(0, 2'b11, 2'b00, 2'b11, 10'h020, Z,   10'h021, Z,   2'b10, 2'b01, D0,  1'b0, 10'h021));
        tbl.push_back(mk(0, 2'b01, 2'b01, 2'b11, 10'h030, D3,  10'h000, Z,   2'b01, 2'b10, D1,  1'b1, 10'h030));
        // Burst write by req1 locks out req0
        tbl.push_back(mk(0, 2'b11, 2'b10, 2'b01, 10'h020, Z,   10'h100, B0,  2'b10, 2'b00, Z,   1'b1, 10'h100));
        tbl.push_back(mk(0, 2'b11, 2'b10, 2'b01, 10'h020, Z,   10'h101, B1,  2'b10, 2'b00, Z,   1'b1, 10'h101));
        tbl.push_back(mk(0, 2'b11, 2'b10, 2'b01, 10'h020, Z,   10'h102, B2,  2'b10, 2'b00, Z,   1'b1, 10'h102));
        tbl.push_back(mk(0, 2'b11, 2'b10, 2'b11, 10'h020, Z,   10'h103, B3,  2'b10, 2'b00, Z,   1'b1, 10'h103));
        tbl.push_back(mk(0, 2'b01, 2'b00, 2'b11, 10'h020, Z,   10'h000, Z,   2'b01, 2'b00, Z,   1'b0, 10'h020));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b11, 10'h000, Z,   10'h000, Z,   2'b00, 2'b01, D0,  1'b0, 10'h000));
        tbl.push_back(mk(0, 2'b10, 2'b00, 2'b11, 10'h000, Z,   10'h100, Z,   2'b10, 2'b00, Z,   1'b0, 10'h100));
        tbl.push_back(mk(0, 2'b10, 2'b00, 2'b11, 10'h000, Z,   10'h101, Z,   2'b10, 2'b10, B0,  1'b0, 10'h101));
        tbl.push_back(mk(0, 2'b10, 2'b00, 2'b11, 10'h000, Z,   10'h102, Z,   2'b10, 2'b10, B1,  1'b0, 10'h102));
        tbl.push_back(mk(0, 2'b10, 2'b00, 2'b11, 10'h000, Z,   10'h103, Z,   2'b10, 2'b10, B2,  1'b0, 10'h103));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b11, 10'h000, Z,   10'h000, Z,   2'b00, 2'b10, B3,  1'b0, 10'h000));
        // Back-to-back read/write/read on one address
        tbl.push_back(mk(0, 2'b01, 2'b01, 2'b11, 10'h010, ONE, 10'h000, Z,   2'b01, 2'b00, Z,   1'b1, 10'h010));
        tbl.push_back(mk(0, 2'b01, 2'b00, 2'b11, 10'h010, Z,   10'h000, Z,   2'b01, 2'b00, Z,   1'b0, 10'h010));
        tbl.push_back(mk(0, 2'b01, 2'b01, 2'b11, 10'h010, TWO, 10'h000, Z,   2'b01, 2'b01, ONE, 1'b1, 10'h010));
        tbl.push_back(mk(0, 2'b01, 2'b00, 2'b11, 10'h010, Z,   10'h000, Z,   2'b01, 2'b00, Z,   1'b0, 10'h010));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b11, 10'h000, Z,   10'h000, Z,   2'b00, 2'b01, TWO, 1'b0, 10'h000));
        // Burst owner gap of three cycles
        tbl.push_back(mk(0, 2'b11, 2'b10, 2'b01, 10'h020, Z,   10'h200, G0,  2'b10, 2'b00, Z,   1'b1, 10'h200));
        tbl.push_back(mk(0, 2'b01, 2'b00, 2'b11, 10'h020, Z,   10'h000, Z,   2'b00, 2'b00, Z,   1'b0, 10'h000));
        tbl.push_back(mk(0, 2'b01, 2'b00, 2'b11, 10'h020, Z,   10'h000, Z,   2'b00, 2'b00, Z,   1'b0, 10'h000));
        tbl.push_back(mk(0, 2'b01, 2'b00, 2'b11, 10'h020, Z,   10'h000, Z,   2'b00, 2'b00, Z,   1'b0, 10'h000));
        tbl.push_back(mk(0, 2'b11, 2'b10, 2'b11, 10'h020, Z,   10'h201, G1,  2'b10, 2'b00, Z,   1'b1, 10'h201));
        tbl.push_back(mk(0, 2'b11, 2'b00, 2'b11, 10'h020, Z,   10'h200, Z,   2'b01, 2'b00, Z,   1'b0, 10'h020));
        tbl.push_back(mk(0, 2'b11, 2'b00, 2'b11, 10'h201, Z,   10'h200, Z,   2'b10, 2'b01, D0,  1'b0, 10'h200));
        tbl.push_back(mk(0, 2'b01, 2'b00, 2'b11, 10'h201, Z,   10'h000, Z,   2'b01, 2'b10, G0,  1'b0, 10'h201));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b11, 10'h000, Z,   10'h000, Z,   2'b00, 2'b01, G1,  1'b0, 10'h000));
        // Reset mid-burst with a read in flight
        tbl.push_back(mk(0, 2'b01, 2'b00, 2'b10, 10'h020, Z,   10'h000, Z,   2'b01, 2'b00, Z,   1'b0, 10'h020));
        tbl.push_back(mk(1, 2'b11, 2'b00, 2'b10, 10'h021, Z,   10'h021, Z,   2'b00, 2'b00, Z,   1'b0, 10'h000));
        tbl.push_back(mk(0, 2'b11, 2'b00, 2'b11, 10'h020, Z,   10'h021, Z,   2'b01, 2'b00, Z,   1'b0, 10'h020));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b11, 10'h000, Z,   10'h000, Z,   2'b00, 2'b01, D0,  1'b0, 10'h000));

        for (int i = 0; i < tbl.size(); i++) begin
            rst       = tbl[i].rst;
            req_valid = tbl[i].v;
            req_we    = tbl[i].we;
            req_last  = tbl[i].last;
            req_addr  = {tbl[i].a1, tbl[i].a0};
            req_wdata = {tbl[i].d1, tbl[i].d0};
            #3;
            chk("req_ready", i, DW'(req_ready), DW'(tbl[i].rdy));
            chk("rsp_valid", i, DW'(rsp_valid), DW'(tbl[i].rsp));
            chk("sram_we",   i, DW'(sram_we),   DW'(tbl[i].swe));
            chk("sram_addr", i, DW'(sram_addr), DW'(tbl[i].saddr));
            if (tbl[i].rsp != 2'b00) chk("rsp_rdata", i, rsp_rdata, tbl[i].rdata);
            @(posedge clk);
            #1;
        end

        // Full-throughput burst read by req1 while req0 waits (ptr is 1 here)
        begin
            logic [DW-1:0] bexp [4];
            bexp[0] = B0; bexp[1] = B1; bexp[2] = B2; bexp[3] = B3;
            for (int k = 0; k < 4; k++) begin
                rst       = 1'b0;
                req_valid = 2'b11;
                req_we    = 2'b00;
                req_last  = {(k == 3), 1'b1};
                req_addr  = {10'h100 + 10'(k), 10'h020};
                req_wdata = '0;
                #3;
                chk("burst_ready", k, DW'(req_ready), DW'(2'b10));
                chk("burst_addr",  k, DW'(sram_addr), DW'(10'h100 + 10'(k)));
                chk("burst_we",    k, DW'(sram_we),   DW'(1'b0));
                if (k > 0) begin
                    chk("burst_rsp",   k, DW'(rsp_valid), DW'(2'b10));
                    chk("burst_rdata", k, rsp_rdata, bexp[k-1]);
                end else begin
                    chk("burst_rsp",   k, DW'(rsp_valid), DW'(2'b00));
                end
                @(posedge clk);
                #1;
            end
            req_valid = 2'b01;
            req_addr  = {10'h000, 10'h020};
            #3;
            chk("after_ready", 0, DW'(req_ready), DW'(2'b01));
            chk("after_rsp",   0, DW'(rsp_valid), DW'(2'b10));
            chk("after_rdata", 0, rsp_rdata, bexp[3]);
            @(posedge clk);
            #1;
            req_valid = 2'b00;
            #3;
            chk("tail_rsp",   0, DW'(rsp_valid), DW'(2'b01));
            chk("tail_rdata", 0, rsp_rdata, D0);
            chk("tail_ready", 0, DW'(req_ready), DW'(2'b00));
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
